// File: rtl/hs_tx_sequencer.sv
// hs_tx_sequencer: D-PHY data lane HS burst sequencer (LP entry, HS-zero, sync, payload, trail, LP exit)
module hs_tx_sequencer #(
    parameter int unsigned T_LPX      = 2,
    parameter int unsigned T_HS_PREP  = 2,
    parameter int unsigned T_HS_ZERO  = 4,
    parameter int unsigned T_HS_TRAIL = 2,
    parameter int unsigned T_HS_EXIT  = 3
) (
    input  logic       TxByteClk,
    input  logic       TxRst,
    input  logic       TxRequestHS,
    input  logic [7:0] TxDataHS,
    output logic       TxReadyHS,
    output logic       TxStopState,
    output logic       LpDp,
    output logic       LpDn,
    output logic       HsEn,
    output logic       serializer_enable,
    output logic [7:0] SerData
);
    typedef enum logic [2:0] {IDLE, LPX, PREP, ZERO, SYNC, DATA, TRAIL, EXIT} state_t;

    // Counter reload value: counts down to 0, so a length of 0 collapses to 1 cycle.
    function automatic logic [7:0] load(input int unsigned t);
        return (t == 0) ? 8'd0 : 8'(t - 1);
    endfunction

    localparam logic [7:0] L_LPX   = load(T_LPX);
    localparam logic [7:0] L_PREP  = load(T_HS_PREP);
    localparam logic [7:0] L_ZERO  = load(T_HS_ZERO);
    localparam logic [7:0] L_TRAIL = load(T_HS_TRAIL);
    localparam logic [7:0] L_EXIT  = load(T_HS_EXIT);

    state_t     state_q;
    logic [7:0] cnt_q, data_q;
    logic       ready_q, stop_q, dp_q, dn_q, hs_q, ser_en_q;

    always_ff @(posedge TxByteClk) begin
        if (TxRst) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            data_q   <= 8'h00;
            ready_q  <= 1'b0;
            stop_q   <= 1'b1;
            dp_q     <= 1'b1;
            dn_q     <= 1'b1;
            hs_q     <= 1'b0;
            ser_en_q <= 1'b0;
        end else begin
            if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
            case (state_q)
                IDLE: if (TxRequestHS) begin
                    state_q <= LPX;
                    cnt_q   <= L_LPX;
                    stop_q  <= 1'b0;
                    dp_q    <= 1'b0;
                end
                LPX: if (cnt_q == 8'd0) begin
                    state_q <= PREP;
                    cnt_q   <= L_PREP;
                    dn_q    <= 1'b0;
                end
                PREP: if (cnt_q == 8'd0) begin
                    state_q  <= ZERO;
                    cnt_q    <= L_ZERO;
                    hs_q     <= 1'b1;
                    ser_en_q <= 1'b1;
                    data_q   <= 8'h00;
                end
                ZERO: if (cnt_q == 8'd0) begin
                    state_q <= SYNC;
                    data_q  <= 8'hB8;
                    ready_q <= 1'b1;
                end
                SYNC, DATA: if (TxRequestHS) begin
                    state_q <= DATA;
                    data_q  <= TxDataHS;
                end else begin
                    // Trail is the inverse of the last serialized bit (bit 7 of the last byte).
                    state_q <= TRAIL;
                    cnt_q   <= L_TRAIL;
                    data_q  <= {8{~data_q[7]}};
                    ready_q <= 1'b0;
                end
                TRAIL: if (cnt_q == 8'd0) begin
                    state_q  <= EXIT;
                    cnt_q    <= L_EXIT;
                    hs_q     <= 1'b0;
                    ser_en_q <= 1'b0;
                    data_q   <= 8'h00;
                    dp_q     <= 1'b1;
                    dn_q     <= 1'b1;
                end
                EXIT: if (cnt_q == 8'd0) begin
                    state_q <= IDLE;
                    stop_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign TxReadyHS         = ready_q;
    assign TxStopState       = stop_q;
    assign LpDp              = dp_q;
    assign LpDn              = dn_q;
    assign HsEn              = hs_q;
    assign serializer_enable = ser_en_q;
    assign SerData           = data_q;
endmodule

// File: tb/tb_hs_tx_sequencer.sv
// tb_hs_tx_sequencer: checks two sequencer instances (default and non-default timing) against a timeline model
module tb_hs_tx_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req [2];
    logic [7:0] dat [2];
    wire  [13:0] o0, o1;
    int vectors = 0, fails = 0;
    int P [2][5] = '{'{2, 2, 4, 2, 3}, '{1, 3, 0, 1, 2}};
    logic [7:0] bytes [8];

    // Observed/expected vector: {stop, dp, dn, hs, ser_en, ready, serdata}
    localparam logic [13:0] IDLE_V = {6'b111000, 8'h00};

    hs_tx_sequencer u0 (
        .TxByteClk(clk), .TxRst(rst), .TxRequestHS(req[0]), .TxDataHS(dat[0]),
        .TxReadyHS(o0[8]), .TxStopState(o0[13]), .LpDp(o0[12]), .LpDn(o0[11]),
        .HsEn(o0[10]), .serializer_enable(o0[9]), .SerData(o0[7:0])
    );

    hs_tx_sequencer #(.T_LPX(1), .T_HS_PREP(3), .T_HS_ZERO(0), .T_HS_TRAIL(1), .T_HS_EXIT(2)) u1 (
        .TxByteClk(clk), .TxRst(rst), .TxRequestHS(req[1]), .TxDataHS(dat[1]),
        .TxReadyHS(o1[8]), .TxStopState(o1[13]), .LpDp(o1[12]), .LpDn(o1[11]),
        .HsEn(o1[10]), .serializer_enable(o1[9]), .SerData(o1[7:0])
    );

    function automatic int eff(input int t);
        return (t == 0) ? 1 : t;
    endfunction

    // Expected outputs k cycles after the IDLE cycle that sampled the request, for an n-byte burst.
    function automatic logic [13:0] model(input int idx, input int k, input int n);
        int lpx, prep, s, t, e;
        logic [7:0] last;
        lpx  = eff(P[idx][0]);
        prep = eff(P[idx][1]);
        s    = 1 + lpx + prep + eff(P[idx][2]);
        t    = s + n + 1;
        e    = t + eff(P[idx][3]);
        last = (n == 0) ? 8'hB8 : bytes[n-1];
        if (k <= 0 || k >= e + eff(P[idx][4])) return IDLE_V;
        if (k <= lpx)        return {6'b001000, 8'h00};
        if (k <= lpx + prep) return {6'b000000, 8'h00};
        if (k < s)           return {6'b000110, 8'h00};
        if (k == s)          return {6'b000111, 8'hB8};
        if (k < t)           return {6'b000111, bytes[k-s-1]};
        if (k < e)           return {6'b000110, {8{~last[7]}}};
        return {6'b011000, 8'h00};
    endfunction

    task automatic check(input int idx, input string tag, input int k, input logic [13:0] ex);
        logic [13:0] ob;
        ob = idx ? o1 : o0;
        vectors++;
        assert (ob === ex) else begin
            fails++;
            $error("FAIL %s u%0d cyc %0d: observed %h expected %h", tag, idx, k, ob, ex);
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            req[0] = 1'b0;
            req[1] = 1'b0;
            @(negedge clk);
            check(0, "idle", i, IDLE_V);
            check(1, "idle", i, IDLE_V);
            @(posedge clk);
            #1;
        end
    endtask

    // Runs one burst from its IDLE request cycle through the last EXIT cycle; abort_k asserts reset.
    task automatic burst(input int idx, input int n, input bit hold, input int abort_k, input string tag);
        int s, last;
        s    = 1 + eff(P[idx][0]) + eff(P[idx][1]) + eff(P[idx][2]);
        last = s + n + eff(P[idx][3]) + eff(P[idx][4]);
        for (int k = 0; k <= last; k++) begin
            if (k == abort_k) rst = 1'b1;
            dat[idx] = 8'($urandom);
            if (k == 0) req[idx] = 1'b1;
            else if (k >= s && k < s + n) begin
                req[idx] = 1'b1;
                dat[idx] = bytes[k-s];
            end else if (k == s + n) req[idx] = 1'b0;
            else req[idx] = hold ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            check(idx, tag, k, model(idx, k, n));
            @(posedge clk);
            #1;
            if (k == abort_k) begin
                rst = 1'b0;
                req[idx] = 1'b0;
                @(negedge clk);
                check(idx, {tag, "_after"}, k + 1, IDLE_V);
                @(posedge clk);
                #1;
                return;
            end
        end
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) bytes[i] = 8'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        req[0] = 1'b1;
        req[1] = 1'b1;
        dat[0] = 8'h00;
        dat[1] = 8'h00;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            check(0, "reset", i, IDLE_V);
            check(1, "reset", i, IDLE_V);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'h81;
        burst(0, 3, 1'b0, -1, "basic");
        idle(1);

        fill(2); bytes[2] = 8'h7F;
        burst(0, 3, 1'b0, -1, "trail7f");
        idle(1);

        burst(0, 0, 1'b0, -1, "zerolen");
        idle(1);

        for (int i = 0; i < 8; i++) begin
            int n;
            n = $urandom_range(0, 6);
            fill(n);
            burst(i % 2, n, 1'b0, -1, "rand");
            idle(1);
        end

        fill(3);
        burst(0, 3, 1'b0, 11, "midrst");
        idle(3);

        fill(2);
        burst(1, 2, 1'b1, -1, "b2b_a");
        fill(1);
        burst(1, 1, 1'b1, -1, "b2b_b");
        burst(1, 0, 1'b1, -1, "b2b_c");
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
